dense_argmax: RTL and testbench
===============================

# dense_argmax

Classification stage directly downstream of the dense layer. It snapshots the NC+1 signed 8-bit class scores that the dense stage produces and scans them sequentially, one score per cycle. It reports the winning class index and its score through a valid/ready handshake to the result consumer (UART/LED/host interface). It can optionally also report the top-1/top-2 confidence margin.

## Interface
- NC, 9: highest class index; the block handles NC+1 scores. Legal range is 1..15.
- IDX_W, 4: width of the class index. Requires 2^IDX_W > NC.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse meaning "dense results are final". It is sampled only in IDLE, or in DONE on the same edge as a handshake.
- result  input  signed [7:0] [0:NC]  class scores from the dense stage. They only need to be valid in the cycle where start is high.
- ready  input  1  consumer accepts the result.
- valid  output  1  classIdx/maxScore (and margin) are valid.
- classIdx  output  IDX_W  index of the maximum score.
- maxScore  output  signed 8  the maximum score.
- busy  output  1  high in SCAN and DONE.
- overrun  output  1  one-cycle pulse when start arrives while the block is busy and the start is not accepted.
- margin  output  9 (unsigned)  maxScore minus second-highest score. This port exists only when DENSE_ARGMAX_MARGIN_EN is defined.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- **IDLE, start=1:**
  - Copy all result[0..NC] into the internal array snap.
  - Load best=result[0], bestIdx=0, idx=1.
  - Load second=-128 (margin build only).
  - Go to SCAN.
- **SCAN, each edge:**
  - Compare x=snap[idx] with a signed comparison.
  - If x > best: best=x and bestIdx=idx; the margin build also sets second=old best.
  - Else, in the margin build only, if x > second: second=x.
  - If idx==NC, go to DONE. Otherwise idx=idx+1.
- **Ties:** the lowest index wins, because the comparison is strictly greater-than. An equal score still updates second, so the margin becomes 0.
- **DONE:**
  - valid=1. classIdx, maxScore and margin stay stable until a handshake.
  - On an edge with valid&&ready, clear valid.
  - If start is also high on that edge, begin a new snapshot and go to SCAN (back-to-back). Otherwise go to IDLE.
- **start while busy:** start in SCAN, or in DONE without ready, is ignored. overrun pulses high for one cycle, the snapshot is untouched and the scan continues.
- **Snapshot isolation:** the result input may change freely after the start cycle without affecting the outcome.
- **Margin arithmetic:** margin = {best[7],best} - {second[7],second}, computed in 9-bit signed and always ≥0. It is output as unsigned 9-bit (max 255, for 127 vs -128).
- **Reset (asynchronous, any state, including mid-scan):**
  - State returns to IDLE.
  - valid, busy, overrun, classIdx, maxScore and margin go to 0.
  - idx and snap are cleared.
  - The scan in progress is discarded and never reported.

## Timing
- start is sampled at edge E0. Scan edges are E1..E(NC). valid is high after E(NC), so 9 cycles for the default NC.
- Throughput is one classification per NC+1 cycles when ready is tied high and start is presented on the handshake edge.
- busy rises after E0 and falls after the handshake edge, unless that edge restarts the block.
- Outputs are registered. There is no combinational path from ready or start to any output.
- The overrun pulse appears in the cycle after the rejected start edge.

## Configuration
- DENSE_ARGMAX_MARGIN_EN defined:
  - second-best tracking is built and the margin port exists.
  - margin follows the rules above and is stable with valid.
- DENSE_ARGMAX_MARGIN_EN undefined:
  - the margin port, second register and 9-bit subtractor are absent.
  - all other behaviour and timing are identical.

## Test plan
- **Basic scan:** result={3,-5,12,7,0,12,-128,1,2,11}, start pulse, ready=1.
  - valid rises 9 cycles after start, with classIdx=2 and maxScore=12. The tie with index 5 resolves to the lower index.
  - margin=0.
- **Extremes and margin:** result all -128 except result[9]=127.
  - classIdx=9, maxScore=127, margin=255.
  - Repeat with all -128: classIdx=0, maxScore=-128, margin=0.
- **Backpressure and isolation:**
  - Hold ready=0 for 20 cycles after valid. Outputs stay stable and valid stays high.
  - Change result mid-scan; the outcome is unchanged.
  - Pulse start during DONE. overrun pulses and the state is unchanged.
- **Back-to-back:** with ready=1, assert start on the handshake edge with new scores {0,0,0,0,50,0,0,0,0,0}.
  - The next valid arrives exactly 9 cycles later with classIdx=4.
- **Reset mid-scan:** assert rst low 4 cycles after start.
  - All outputs read 0 immediately and the FSM is in IDLE.
  - A fresh start after reset release produces a correct result with no residue from the aborted scan.
- **Build without DENSE_ARGMAX_MARGIN_EN:** rerun the first two scenarios. classIdx, maxScore and timing match the margin build.

Source files
------------

// File: rtl/dense_argmax.sv
// dense_argmax: snapshots NC+1 signed 8-bit class scores and scans them one
// per cycle, reporting the winning index and score over a valid/ready handshake.
// Optional build macro DENSE_ARGMAX_MARGIN_EN adds second-best tracking and
// the 9-bit top-1/top-2 margin output.
module dense_argmax #(
    parameter int unsigned NC    = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [7:0]      result [0:NC],
    input  logic                   ready,
    output logic                   valid,
    output logic [IDX_W-1:0]       classIdx,
    output logic signed [7:0]      maxScore,
    output logic                   busy,
    output logic                   overrun
`ifdef DENSE_ARGMAX_MARGIN_EN
    ,
    output logic [8:0]             margin
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NC);
    localparam logic signed [7:0] MIN_SCORE = 8'sh80;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                  state;
    logic signed [7:0]       snap [0:NC];
    logic [IDX_W-1:0]        idx;
    logic signed [7:0]       best;
    logic [IDX_W-1:0]        best_idx;

    logic signed [7:0]       cur;
    logic signed [7:0]       best_nx;
    logic [IDX_W-1:0]        best_idx_nx;
    logic                    accept_start;
    logic                    reject_start;

`ifdef DENSE_ARGMAX_MARGIN_EN
    logic signed [7:0]       second;
    logic signed [7:0]       second_nx;
    logic [8:0]              margin_nx;
`endif

    assign cur = snap[idx];

    // Start is honoured in IDLE, or in DONE on the handshake edge; otherwise it is an overrun
    assign accept_start = start && ((state == IDLE) || ((state == DONE) && ready));
    assign reject_start = start && ((state == SCAN) || ((state == DONE) && !ready));

    // Running max update for the current scan element; strict > keeps the lowest index on ties
    always_comb begin
        best_nx     = best;
        best_idx_nx = best_idx;
`ifdef DENSE_ARGMAX_MARGIN_EN
        second_nx   = second;
`endif
        if (cur > best) begin
            best_nx     = cur;
            best_idx_nx = idx;
`ifdef DENSE_ARGMAX_MARGIN_EN
            second_nx   = best;
`endif
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        else if (cur > second) begin
            second_nx = cur;
        end
`endif
    end

`ifdef DENSE_ARGMAX_MARGIN_EN
    // Sign-extended 9-bit difference; never negative because best >= second
    assign margin_nx = {best_nx[7], best_nx} - {second_nx[7], second_nx};
`endif

    // Control FSM, snapshot capture, scan datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            valid    <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            classIdx <= '0;
            maxScore <= '0;
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
            for (int i = 0; i <= int'(NC); i++) begin
                snap[i] <= '0;
            end
`ifdef DENSE_ARGMAX_MARGIN_EN
            second   <= '0;
            margin   <= '0;
`endif
        end else begin
            overrun <= reject_start;
            if (accept_start) begin
                for (int i = 0; i <= int'(NC); i++) begin
                    snap[i] <= result[i];
                end
                best     <= result[0];
                best_idx <= '0;
                idx      <= IDX_W'(1);
`ifdef DENSE_ARGMAX_MARGIN_EN
                second   <= MIN_SCORE;
`endif
                valid    <= 1'b0;
                busy     <= 1'b1;
                state    <= SCAN;
            end else begin
                case (state)
                    SCAN: begin
                        best     <= best_nx;
                        best_idx <= best_idx_nx;
`ifdef DENSE_ARGMAX_MARGIN_EN
                        second   <= second_nx;
`endif
                        if (idx == LAST_IDX) begin
                            classIdx <= best_idx_nx;
                            maxScore <= best_nx;
`ifdef DENSE_ARGMAX_MARGIN_EN
                            margin   <= margin_nx;
`endif
                            valid    <= 1'b1;
                            state    <= DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    DONE: begin
                        if (ready) begin
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    IDLE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef DENSE_ARGMAX_MARGIN_EN
    // The minimum-score constant is only used by second-best tracking
    logic unused_min;
    assign unused_min = ^MIN_SCORE;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Directed testbench for dense_argmax (default NC=9, IDX_W=4).
// Define DENSE_ARGMAX_MARGIN_EN to also check the margin port.
module tb_dense_argmax;

    logic              clk;
    logic              rst;
    logic              start;
    logic signed [7:0] result [0:9];
    logic              ready;
    logic              valid;
    logic [3:0]        classIdx;
    logic signed [7:0] maxScore;
    logic              busy;
    logic              overrun;
`ifdef DENSE_ARGMAX_MARGIN_EN
    logic [8:0]        margin;
`endif

    int checks;
    int failures;

    dense_argmax #(.NC(9), .IDX_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .result   (result),
        .ready    (ready),
        .valid    (valid),
        .classIdx (classIdx),
        .maxScore (maxScore),
        .busy     (busy),
        .overrun  (overrun)
`ifdef DENSE_ARGMAX_MARGIN_EN
        ,
        .margin   (margin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load ten scores, element 0 in the top byte
    task automatic set_scores(input logic [79:0] v);
        for (int i = 0; i < 10; i++) begin
            result[i] = v[79 - 8*i -: 8];
        end
    endtask

    // Present start with the given scores for one edge (E0); returns #1 after E0
    task automatic start_scan(input logic [79:0] v);
        set_scores(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until valid is seen, bounded at 30
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (cycles < 30) begin
            @(posedge clk);
            #1;
            cycles++;
            if (valid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; ready = 1'b0;
        set_scores(80'h1122334455667788_99AA);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || classIdx !== 4'd0 || maxScore !== 8'sd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b busy=%b ovr=%b idx=%0d max=%0d, want all 0",
                     valid, busy, overrun, classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd0) begin
            failures++;
            $display("FAIL reset_margin: got %0d want 0", margin);
        end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cyc;
        ready = 1'b1;
        // {3,-5,12,7,0,12,-128,1,2,11}
        start_scan({8'd3, 8'hFB, 8'd12, 8'd7, 8'd0, 8'd12, 8'h80, 8'd1, 8'd2, 8'd11});
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_rise: got %b want 1", busy);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles want 9", cyc);
        end
        checks++;
        if (classIdx !== 4'd2 || maxScore !== 8'sd12) begin
            failures++;
            $display("FAIL basic_result: got idx=%0d max=%0d want idx=2 max=12", classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd0) begin
            failures++;
            $display("FAIL basic_margin: got %0d want 0", margin);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_handshake: got valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_extremes();
        int cyc;
        ready = 1'b1;
        start_scan({{9{8'h80}}, 8'h7F});
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || classIdx !== 4'd9 || maxScore !== 8'sd127) begin
            failures++;
            $display("FAIL ext_max_last: got cyc=%0d idx=%0d max=%0d want 9 9 127", cyc, classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd255) begin
            failures++;
            $display("FAIL ext_margin_255: got %0d want 255", margin);
        end
`endif
        @(posedge clk);
        #1;
        start_scan({10{8'h80}});
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || classIdx !== 4'd0 || maxScore !== -8'sd128) begin
            failures++;
            $display("FAIL ext_all_min: got cyc=%0d idx=%0d max=%0d want 9 0 -128", cyc, classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd0) begin
            failures++;
            $display("FAIL ext_margin_0: got %0d want 0", margin);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        int unstable;
        ready = 1'b0;
        // {1,2,3,4,5,6,7,8,9,-1}: max 9 at index 8, second 8
        start_scan({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'hFF});
        set_scores({10{8'd100}});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun_scan: got %b want 1", overrun);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL bp_latency: got %0d want 8 more cycles", cyc);
        end
        checks++;
        if (classIdx !== 4'd8 || maxScore !== 8'sd9) begin
            failures++;
            $display("FAIL bp_isolation: got idx=%0d max=%0d want 8 9", classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd1) begin
            failures++;
            $display("FAIL bp_margin: got %0d want 1", margin);
        end
`endif
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b1 || classIdx !== 4'd8 || maxScore !== 8'sd9 || busy !== 1'b1) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (overrun !== 1'b1 || valid !== 1'b1 || classIdx !== 4'd8 || maxScore !== 8'sd9) begin
            failures++;
            $display("FAIL bp_overrun_done: got ovr=%b valid=%b idx=%0d max=%0d want 1 1 8 9",
                     overrun, valid, classIdx, maxScore);
        end
        @(posedge clk);
        #1;
        checks++;
        if (overrun !== 1'b0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun_pulse: got ovr=%b valid=%b want 0 1", overrun, valid);
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        ready = 1'b1;
        start_scan({8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1});
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || classIdx !== 4'd0 || maxScore !== 8'sd5) begin
            failures++;
            $display("FAIL b2b_first: got cyc=%0d idx=%0d max=%0d want 9 0 5", cyc, classIdx, maxScore);
        end
        start_scan({8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: got valid=%b busy=%b ovr=%b want 0 1 0", valid, busy, overrun);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || classIdx !== 4'd4 || maxScore !== 8'sd50) begin
            failures++;
            $display("FAIL b2b_second: got cyc=%0d idx=%0d max=%0d want 9 4 50", cyc, classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd50) begin
            failures++;
            $display("FAIL b2b_margin: got %0d want 50", margin);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        ready = 1'b1;
        start_scan({8'd1, 8'd1, 8'd1, 8'd120, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || classIdx !== 4'd0 || maxScore !== 8'sd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got valid=%b busy=%b ovr=%b idx=%0d max=%0d want all 0",
                     valid, busy, overrun, classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd0) begin
            failures++;
            $display("FAIL rst_mid_margin: got %0d want 0", margin);
        end
`endif
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_report: got valid=%b want 0", valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        // {-3,-1,-2,-9,-7,-1,-4,-5,-6,-8}: max -1 at index 1, tie at 5
        start_scan({8'hFD, 8'hFF, 8'hFE, 8'hF7, 8'hF9, 8'hFF, 8'hFC, 8'hFB, 8'hFA, 8'hF8});
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_restart: got ovr=%b busy=%b want 0 1", overrun, busy);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 9 || classIdx !== 4'd1 || maxScore !== -8'sd1) begin
            failures++;
            $display("FAIL rst_mid_fresh: got cyc=%0d idx=%0d max=%0d want 9 1 -1", cyc, classIdx, maxScore);
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 9'd0) begin
            failures++;
            $display("FAIL rst_mid_fresh_margin: got %0d want 0", margin);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
